// File: rtl/dc_write_buffer.sv
// Posted write buffer between the data cache memory port and data memory: coalesces, forwards, drains FIFO.
// Optional statistics counters are enabled with `define DC_WRITE_BUFFER_STATS_EN.
module dc_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          C_READ,
    input  logic          C_WRITE,
    input  logic [AW-1:0] C_ADDRESS,
    input  logic [DW-1:0] C_WRITEDATA,
    output logic [DW-1:0] C_READDATA,
    output logic          C_BUSYWAIT,
    output logic          M_READ,
    output logic          M_WRITE,
    output logic [AW-1:0] M_ADDRESS,
    output logic [DW-1:0] M_WRITEDATA,
    input  logic [DW-1:0] M_READDATA,
    input  logic          M_BUSYWAIT
`ifdef DC_WRITE_BUFFER_STATS_EN
    ,
    output logic [15:0]   STAT_COALESCE,
    output logic [15:0]   STAT_FULLSTALL
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_READ, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q;
    logic             m_read_q, m_read_d, m_write_q, m_write_d, req_seen_q;
    logic [AW-1:0]    m_addr_q, m_addr_d;
    logic [DW-1:0]    m_wdata_q, m_wdata_d, rd_latch_q, rd_latch_d;

    logic [DEPTH-1:0] hit_vec, wr_hit_vec;
    logic             rd_hit, wr_hit;
    logic [PW-1:0]    rd_idx, wr_idx;
    logic             full, mem_done, drain_done, wr_accept, push, rd_miss;

    // The head entry is excluded from coalescing while its data is already on the memory bus.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign hit_vec[gi]    = valid_q[gi] && (addr_q[gi] == C_ADDRESS);
            assign wr_hit_vec[gi] = hit_vec[gi] && !((state_q == S_DRAIN) && (head_q == PW'(gi)));
        end
    endgenerate

    always_comb begin
        wr_idx = '0;
        rd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit_vec[i])    rd_idx = PW'(i);
            if (wr_hit_vec[i]) wr_idx = PW'(i);
        end
        wr_hit = |wr_hit_vec;
        rd_hit = |hit_vec;
        // A fresh copy beats a head that is mid-drain with stale data.
        if (wr_hit) rd_idx = wr_idx;
    end

    assign full       = (count_q == CW'(DEPTH));
    assign mem_done   = (m_read_q || m_write_q) && req_seen_q && !M_BUSYWAIT;
    assign drain_done = (state_q == S_DRAIN) && mem_done;
    assign wr_accept  = C_WRITE && (wr_hit || !full || drain_done);
    assign push       = wr_accept && !wr_hit;
    assign rd_miss    = C_READ && !C_WRITE && !rd_hit;

    always_comb begin
        C_BUSYWAIT = 1'b0;
        C_READDATA = '0;
        if (C_WRITE) begin
            C_BUSYWAIT = !wr_accept;
        end else if (C_READ) begin
            if (rd_hit)                 C_READDATA = data_q[rd_idx];
            else if (state_q == S_RESP) C_READDATA = rd_latch_q;
            else                        C_BUSYWAIT = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        m_read_d   = m_read_q;
        m_write_d  = m_write_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        rd_latch_d = rd_latch_q;
        unique case (state_q)
            S_IDLE: begin
                if (rd_miss) begin
                    state_d  = S_READ;
                    m_read_d = 1'b1;
                    m_addr_d = C_ADDRESS;
                end else if (count_q != '0) begin
                    state_d   = S_DRAIN;
                    m_write_d = 1'b1;
                    m_addr_d  = addr_q[head_q];
                    // Bypass a same-cycle coalesce into the head so the memory sees the newest data.
                    m_wdata_d = (wr_accept && wr_hit && (wr_idx == head_q)) ? C_WRITEDATA
                                                                            : data_q[head_q];
                end
            end
            S_DRAIN: begin
                if (mem_done) begin
                    state_d   = S_IDLE;
                    m_write_d = 1'b0;
                end
            end
            S_READ: begin
                if (mem_done) begin
                    state_d    = S_RESP;
                    m_read_d   = 1'b0;
                    rd_latch_d = M_READDATA;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            m_read_q   <= 1'b0;
            m_write_q  <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            rd_latch_q <= '0;
            req_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_read_q   <= m_read_d;
            m_write_q  <= m_write_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            rd_latch_q <= rd_latch_d;
            req_seen_q <= (m_read_q || m_write_q) && !mem_done;
        end
    end

    // Pop is applied before push so a full buffer can retire and accept on the same edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (drain_done) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            if (wr_accept) begin
                if (wr_hit) begin
                    data_q[wr_idx] <= C_WRITEDATA;
                end else begin
                    valid_q[tail_q] <= 1'b1;
                    addr_q[tail_q]  <= C_ADDRESS;
                    data_q[tail_q]  <= C_WRITEDATA;
                    tail_q          <= tail_q + PW'(1);
                end
            end
            count_q <= count_q + CW'(push) - CW'(drain_done);
        end
    end

    assign M_READ      = m_read_q;
    assign M_WRITE     = m_write_q;
    assign M_ADDRESS   = m_addr_q;
    assign M_WRITEDATA = m_wdata_q;

`ifdef DC_WRITE_BUFFER_STATS_EN
    logic [15:0] stat_coal_q, stat_stall_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stat_coal_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            if (wr_accept && wr_hit && (stat_coal_q != 16'hFFFF)) stat_coal_q <= stat_coal_q + 16'd1;
            if (C_WRITE && full && (stat_stall_q != 16'hFFFF))    stat_stall_q <= stat_stall_q + 16'd1;
        end
    end

    assign STAT_COALESCE  = stat_coal_q;
    assign STAT_FULLSTALL = stat_stall_q;
`endif

endmodule
